// File: rtl/mux_reg_pkg.sv
// ============================================================================
//  mux_reg_pkg
//  Shared constants, select-width helper and stage record for mux_reg_pipe.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mux_reg_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_IN = 4;
  localparam int DEF_DEPTH  = 2;

  // A select field never collapses to zero width, even for a single channel.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_SEL_W = sel_w(DEF_NUM_IN);

  typedef struct packed {
    logic                 valid;
    logic [DEF_SEL_W-1:0] sel;
    logic                 err;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/mux_reg_stage.sv
// ============================================================================
//  mux_reg_stage
//  One pipeline register: async active-low reset, synchronous clear, enable.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mux_reg_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_reg_pipe.sv
// ============================================================================
//  mux_reg_pipe
//  NUM_IN:1 word mux feeding a DEPTH-stage stallable pipeline with valid,
//  source-channel and select-error tags. Optional macro MUX_REG_AUTOSCAN_EN
//  adds the auto_mode port and an internal round-robin scan counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mux_reg_pipe
  import mux_reg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [NUM_IN*WIDTH-1:0]    din,
  input  logic [sel_w(NUM_IN)-1:0]   sel,
`ifdef MUX_REG_AUTOSCAN_EN
  input  logic                       auto_mode,
`endif
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qbar,
  output logic                       out_valid,
  output logic [sel_w(NUM_IN)-1:0]   out_sel,
  output logic                       sel_err
);

  localparam int SEL_W = sel_w(NUM_IN);

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] sel;
    logic             err;
    logic [WIDTH-1:0] data;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  logic [SEL_W-1:0] w_eff_sel;
  logic [WIDTH-1:0] w_data;
  logic             w_err;
  rec_t             w_pipe [DEPTH+1];

`ifdef MUX_REG_AUTOSCAN_EN
  logic [SEL_W-1:0] r_scan;

  // Wraps at NUM_IN-1 so autoscan can never raise a select error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan <= '0;
    end else if (clr) begin
      r_scan <= '0;
    end else if (en && auto_mode && in_valid) begin
      r_scan <= (r_scan == SEL_W'(NUM_IN - 1)) ? '0 : r_scan + 1'b1;
    end
  end

  assign w_eff_sel = auto_mode ? r_scan : sel;
`else
  assign w_eff_sel = sel;
`endif

  // Unmatched select leaves word 0 (zero) with the error flag raised.
  always_comb begin
    w_data = '0;
    w_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_eff_sel == SEL_W'(k)) begin
        w_data = din[k*WIDTH +: WIDTH];
        w_err  = 1'b0;
      end
    end
  end

  assign w_pipe[0] = {in_valid, w_eff_sel, w_err, w_data};

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      mux_reg_stage #(
        .W (REC_W)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_en  (en),
        .i_d   (w_pipe[i]),
        .o_q   (w_pipe[i+1])
      );
    end
  endgenerate

  assign q         = w_pipe[DEPTH].data;
  assign qbar      = ~q;
  assign out_valid = w_pipe[DEPTH].valid;
  assign out_sel   = w_pipe[DEPTH].sel;
  assign sel_err   = w_pipe[DEPTH].err;

endmodule

`default_nettype wire

// File: tb/tb_mux_reg_pipe.sv
// Bench for mux_reg_pipe: a 4-input and a 3-input instance (WIDTH=8, DEPTH=2)
// checked against directed tables and a latency-queue reference model.
`default_nettype none

module tb_mux_reg_pipe;

  localparam int D = 2;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       e;
    logic [7:0] d;
  } rec_t;

  typedef struct {
    logic [1:0] sel;
    logic       iv;
    logic       en;
    logic       clr;
    logic [7:0] exp_q;
    logic       exp_v;
    logic [1:0] exp_sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, clr, in_valid, auto_mode;
  logic [31:0] din_a;
  logic [23:0] din_b;
  logic [1:0]  sel;
  logic [7:0]  q_a, qbar_a, q_b, qbar_b;
  logic        v_a, v_b, err_a, err_b;
  logic [1:0]  os_a, os_b;

  int n_chk  = 0;
  int n_fail = 0;

  rec_t qa[$];
  rec_t qb[$];
  int   sc_a = 0;
  int   sc_b = 0;

  always #5 clk = ~clk;

  mux_reg_pipe #(.WIDTH(8), .NUM_IN(4), .DEPTH(D)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
    .din(din_a), .sel(sel),
`ifdef MUX_REG_AUTOSCAN_EN
    .auto_mode(auto_mode),
`endif
    .q(q_a), .qbar(qbar_a), .out_valid(v_a), .out_sel(os_a), .sel_err(err_a)
  );

  mux_reg_pipe #(.WIDTH(8), .NUM_IN(3), .DEPTH(D)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
    .din(din_b), .sel(sel),
`ifdef MUX_REG_AUTOSCAN_EN
    .auto_mode(auto_mode),
`endif
    .q(q_b), .qbar(qbar_b), .out_valid(v_b), .out_sel(os_b), .sel_err(err_b)
  );

  function automatic rec_t mk(input logic [31:0] d, input int s, input int n, input logic iv);
    rec_t r;
    r.v = iv;
    r.s = s[1:0];
    r.e = (s >= n);
    r.d = (s < n) ? d[s*8 +: 8] : 8'h00;
    return r;
  endfunction

  function automatic int eff(input int sc);
`ifdef MUX_REG_AUTOSCAN_EN
    if (auto_mode) return sc;
`endif
    return int'(sel);
  endfunction

  // Reference: output equals the sample accepted D enabled edges ago, or
  // all-zero if fewer than D enabled edges have passed since reset/clear.
  always @(posedge clk) begin
    if (rst) begin
      if (clr) begin
        qa.delete(); qb.delete(); sc_a = 0; sc_b = 0;
      end else if (en) begin
        qa.push_front(mk(din_a, eff(sc_a), 4, in_valid));
        qb.push_front(mk({8'h00, din_b}, eff(sc_b), 3, in_valid));
        if (qa.size() > D) void'(qa.pop_back());
        if (qb.size() > D) void'(qb.pop_back());
        if (auto_mode && in_valid) begin
          sc_a = (sc_a + 1) % 4;
          sc_b = (sc_b + 1) % 3;
        end
      end
    end
  end

  always @(negedge rst) begin
    qa.delete(); qb.delete(); sc_a = 0; sc_b = 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_models();
    rec_t ea, eb;
    ea = '{v: 1'b0, s: 2'd0, e: 1'b0, d: 8'h00};
    eb = ea;
    if (qa.size() >= D) ea = qa[D-1];
    if (qb.size() >= D) eb = qb[D-1];
    chk("a.q",    {24'h0, q_a},    {24'h0, ea.d});
    chk("a.qbar", {24'h0, qbar_a}, {24'h0, ~ea.d});
    chk("a.valid", {31'h0, v_a},   {31'h0, ea.v});
    chk("a.sel",  {30'h0, os_a},   {30'h0, ea.s});
    chk("a.err",  {31'h0, err_a},  {31'h0, ea.e});
    chk("b.q",    {24'h0, q_b},    {24'h0, eb.d});
    chk("b.qbar", {24'h0, qbar_b}, {24'h0, ~eb.d});
    chk("b.valid", {31'h0, v_b},   {31'h0, eb.v});
    chk("b.sel",  {30'h0, os_b},   {30'h0, eb.s});
    chk("b.err",  {31'h0, err_b},  {31'h0, eb.e});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".q"},    {24'h0, q_a},    32'h00);
    chk({tag, ".qbar"}, {24'h0, qbar_a}, 32'hFF);
    chk({tag, ".valid"}, {31'h0, v_a},   32'h0);
    chk({tag, ".sel"},  {30'h0, os_a},   32'h0);
    chk({tag, ".err"},  {31'h0, err_a},  32'h0);
    chk({tag, ".b.q"},  {24'h0, q_b},    32'h00);
    chk({tag, ".b.qbar"}, {24'h0, qbar_b}, 32'hFF);
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    cmp_models();
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{sel: 2'd0, iv: 1, en: 1, clr: 0, exp_q: 8'h00, exp_v: 0, exp_sel: 2'd0};
    tbl[1]  = '{sel: 2'd1, iv: 1, en: 1, clr: 0, exp_q: 8'h11, exp_v: 1, exp_sel: 2'd0};
    tbl[2]  = '{sel: 2'd2, iv: 1, en: 1, clr: 0, exp_q: 8'h22, exp_v: 1, exp_sel: 2'd1};
    tbl[3]  = '{sel: 2'd3, iv: 1, en: 1, clr: 0, exp_q: 8'h33, exp_v: 1, exp_sel: 2'd2};
    tbl[4]  = '{sel: 2'd0, iv: 0, en: 0, clr: 0, exp_q: 8'h33, exp_v: 1, exp_sel: 2'd2};
    tbl[5]  = '{sel: 2'd1, iv: 0, en: 0, clr: 0, exp_q: 8'h33, exp_v: 1, exp_sel: 2'd2};
    tbl[6]  = '{sel: 2'd2, iv: 0, en: 0, clr: 0, exp_q: 8'h33, exp_v: 1, exp_sel: 2'd2};
    tbl[7]  = '{sel: 2'd0, iv: 0, en: 1, clr: 0, exp_q: 8'h44, exp_v: 1, exp_sel: 2'd3};
    tbl[8]  = '{sel: 2'd1, iv: 1, en: 1, clr: 0, exp_q: 8'h11, exp_v: 0, exp_sel: 2'd0};
    tbl[9]  = '{sel: 2'd1, iv: 1, en: 1, clr: 1, exp_q: 8'h00, exp_v: 0, exp_sel: 2'd0};
    tbl[10] = '{sel: 2'd2, iv: 1, en: 1, clr: 0, exp_q: 8'h00, exp_v: 0, exp_sel: 2'd0};
    tbl[11] = '{sel: 2'd3, iv: 1, en: 1, clr: 0, exp_q: 8'h33, exp_v: 1, exp_sel: 2'd2};

    rst = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; sel = 2'd0; auto_mode = 1'b0;
    din_a = 32'h44332211;
    din_b = 24'h332211;
    #12;
    chk_reset_outputs("reset");

    // Directed stream, stall, valid drop and clear.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sel = tbl[i].sel; in_valid = tbl[i].iv; en = tbl[i].en; clr = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.q", i),     {24'h0, q_a},    {24'h0, tbl[i].exp_q});
      chk($sformatf("tbl%0d.qbar", i),  {24'h0, qbar_a}, {24'h0, ~tbl[i].exp_q});
      chk($sformatf("tbl%0d.valid", i), {31'h0, v_a},    {31'h0, tbl[i].exp_v});
      chk($sformatf("tbl%0d.sel", i),   {30'h0, os_a},   {30'h0, tbl[i].exp_sel});
      cmp_models();
    end

    // Out-of-range select on the 3-input instance.
    sel = 2'd3; in_valid = 1'b1; en = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
    sel = 2'd0;
    @(posedge clk);
    #1;
    chk("oor.q",   {24'h0, q_b},   32'h00);
    chk("oor.err", {31'h0, err_b}, 32'h1);
    chk("oor.sel", {30'h0, os_b},  32'h3);
    chk("oor.valid", {31'h0, v_b}, 32'h1);
    cmp_models();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      din_a    = $urandom;
      din_b    = 24'($urandom);
      sel      = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      en       = ($urandom_range(0, 9) < 8);
      clr      = ($urandom_range(0, 19) == 0);
      edge_check();
    end

    // Asynchronous reset mid-stream, taking effect between edges.
    en = 1'b1; clr = 1'b0; in_valid = 1'b1; sel = 2'd3; din_a = 32'hA5C3_7E19;
    edge_check();
    edge_check();
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    edge_check();
    chk("restart.valid", {31'h0, v_a}, 32'h0);
    edge_check();
    chk("restart.q", {24'h0, q_a}, {24'h0, din_a[31:24]});

`ifdef MUX_REG_AUTOSCAN_EN
    begin
      logic [1:0] exp_s [4];
      exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};
      clr = 1'b1; en = 1'b1;
      edge_check();
      clr = 1'b0; auto_mode = 1'b1; in_valid = 1'b1; sel = 2'd3;
      edge_check();
      for (int i = 0; i < 4; i++) begin
        edge_check();
        chk($sformatf("scan%0d.sel", i), {30'h0, os_b}, {30'h0, exp_s[i]});
        chk($sformatf("scan%0d.err", i), {31'h0, err_b}, 32'h0);
      end
      in_valid = 1'b0;
      edge_check();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) edge_check();
      auto_mode = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
